// File: rtl/ps2_key_controller.sv
// PS/2 keyboard front end for the KEY instruction: conditions the pins, receives and
// validates frames, keeps make codes only and buffers them in a show-ahead FIFO.
module ps2_key_controller #(
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2Clock,
    input  logic       iPS2Data,
    input  logic       iKeyRead,
    output logic [7:0] oKeyData,
    output logic       oKeyValid,
    output logic       oStall,
    output logic       oFrameError,
    output logic       oOverflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] samp_q, samp_d;
    logic                  filt_q, filt_d, prev_q, fall_q;
    logic                  dat;

    state_e                state_q, state_d;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic                  par_q;
    logic [TW-1:0]         to_q;
    logic                  frame_ok, frame_bad, err_q;

    logic                  brk_q, brk_d, push;

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, rp_q;
    logic [PW:0]           cnt_q;
    logic                  full, pop, wr, ovf_q;

    assign dat = dat_sync_q[1];

    // The filtered level only moves once every sample in the window agrees.
    assign samp_d = {samp_q[FILTER_LEN-2:0], clk_sync_q[1]};
    always_comb begin
        filt_d = filt_q;
        if (samp_d == '0)      filt_d = 1'b0;
        else if (samp_d == '1) filt_d = 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            samp_q     <= '1;
            filt_q     <= 1'b1;
            prev_q     <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], iPS2Clock};
            dat_sync_q <= {dat_sync_q[0], iPS2Data};
            samp_q     <= samp_d;
            filt_q     <= filt_d;
            prev_q     <= filt_q;
            fall_q     <= prev_q & ~filt_q;
        end
    end

    // Receiver FSM: state register plus frame datapath
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fall_q) begin
                to_q <= '0;
                if (state_q == IDLE) bit_q <= '0;
                if (state_q == DATA) begin
                    shift_q <= {dat, shift_q[7:1]};
                    bit_q   <= bit_q + 1'b1;
                end
                if (state_q == PARITY) par_q <= dat;
            end else begin
                to_q <= (state_d == IDLE) ? '0 : to_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (fall_q) begin
            case (state_q)
                IDLE:    if (!dat) state_d = DATA;
                DATA:    if (bit_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        frame_ok  = fall_q && (state_q == STOP) && dat && (^{shift_q, par_q});
        frame_bad = fall_q && (state_q == STOP) && !frame_ok;
    end

    // Decoder: drop E0 prefixes and every F0-prefixed release code.
    always_comb begin
        brk_d = brk_q;
        push  = 1'b0;
        if (frame_ok) begin
            if (shift_q == 8'hF0)      brk_d = 1'b1;
            else if (shift_q == 8'hE0) brk_d = brk_q;
            else if (brk_q)            brk_d = 1'b0;
            else                       push  = 1'b1;
        end
    end

    assign full = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign pop  = iKeyRead & oKeyValid;
    assign wr   = push & (~full | pop);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
            brk_q <= 1'b0;
            ovf_q <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            err_q <= frame_bad;
            brk_q <= brk_d;
            if (push & full & ~pop) ovf_q <= 1'b1;
            if (wr) begin
                mem_q[wp_q] <= shift_q;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            case ({wr, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign oKeyValid   = (cnt_q != '0);
    assign oKeyData    = oKeyValid ? mem_q[rp_q] : 8'h00;
    assign oStall      = iKeyRead & ~oKeyValid;
    assign oFrameError = err_q;
    assign oOverflow   = ovf_q;
endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller: directed PS/2 frames, expected codes queued
// at stimulus time and checked by a monitor whenever a KEY read pops the FIFO.
module tb_ps2_key_controller;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 400;
    localparam int HALF  = 20;
    localparam int BOUND = 3000;

    logic       clk = 1'b0, rst_n = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rd = 1'b0;
    logic [7:0] kdata;
    logic       kvalid, stall, ferr, ovf;

    int n_chk = 0, n_fail = 0, err_seen = 0, err_exp = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_key_controller #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .Clock(clk), .Reset(rst_n), .iPS2Clock(ps2c), .iPS2Data(ps2d), .iKeyRead(rd),
        .oKeyData(kdata), .oKeyValid(kvalid), .oStall(stall),
        .oFrameError(ferr), .oOverflow(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends the first nbits of a frame; all tasks start and end at posedge+1.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit lat);
        logic [10:0] frm;
        frm = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = frm[i];
            repeat (HALF) @(posedge clk);
            #1 ps2c = 1'b0;
            for (int j = 0; j < HALF; j++) begin
                @(posedge clk);
                #1;
                if (lat && i == 10 && j == FL + 2) chk("latency_early", kvalid, 0);
                if (lat && i == 10 && j == FL + 3) begin
                    chk("latency_valid", kvalid, 1);
                    chk("latency_data", kdata, 8'h1C);
                end
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic read_key(input bit exp_stall);
        int n = 0;
        rd = 1'b1;
        #1;
        if (exp_stall) chk("stall_on_empty", stall, 1);
        while (!kvalid && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!kvalid) chk("read_timeout", kvalid, 1);
        else         chk("stall_released", stall, 0);
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) err_seen++;
            if (rd && kvalid) begin
                if (exp_q.size() == 0) chk("unexpected_pop", kdata, 32'hFFFF_FFFF);
                else                   chk("pop_data", kdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rd = 1'b1;
        #1;
        chk("rst_valid", kvalid, 0);
        chk("rst_data", kdata, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_stall_hi", stall, 1);
        rd = 1'b0;
        #1 chk("rst_stall_lo", stall, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // single make code, latency and pop
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 0, 11, 1);
        read_key(0);
        chk("after_pop_valid", kvalid, 0);
        chk("after_pop_data", kdata, 0);

        // break and extended prefixes filtered
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h75);
        send_frame(8'h1C, 0, 11, 0);
        send_frame(8'hF0, 0, 11, 0);
        send_frame(8'h1C, 0, 11, 0);
        send_frame(8'hE0, 0, 11, 0);
        send_frame(8'h75, 0, 11, 0);
        chk("filter_valid", kvalid, 1);
        read_key(0);
        read_key(0);
        chk("filter_empty", kvalid, 0);

        // parity error
        send_frame(8'h32, 1, 11, 0);
        err_exp++;
        chk("parity_err_count", err_seen, err_exp);
        chk("parity_no_push", kvalid, 0);

        // overflow, then drain with wrap
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h1D);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h2D);
        send_frame(8'h15, 0, 11, 0);
        send_frame(8'h1D, 0, 11, 0);
        send_frame(8'h24, 0, 11, 0);
        send_frame(8'h2D, 0, 11, 0);
        chk("full_no_ovf", ovf, 0);
        send_frame(8'h2C, 0, 11, 0);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 4; i++) read_key(0);
        fork
            begin
                for (int i = 0; i < 6; i++) read_key(i == 0);
            end
            begin
                logic [7:0] codes [6];
                codes = '{8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};
                for (int k = 0; k < 6; k++) begin
                    exp_q.push_back(codes[k]);
                    send_frame(codes[k], 0, 11, 0);
                end
            end
        join
        chk("ovf_sticky", ovf, 1);
        chk("wrap_empty", kvalid, 0);

        // read held on empty FIFO until a key arrives
        fork
            read_key(1);
            begin
                exp_q.push_back(8'h29);
                send_frame(8'h29, 0, 11, 0);
            end
        join
        chk("stall_drained", kvalid, 0);

        // reset mid-frame
        send_frame(8'h5A, 0, 5, 0);
        rd = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", kvalid, 0);
        chk("midrst_data", kdata, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_stall", stall, 1);
        rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 0, 11, 0);
        read_key(0);
        chk("midrst_one_code", kvalid, 0);
        chk("midrst_no_err", err_seen, err_exp);

        // PS/2 clock stall past timeout
        send_frame(8'h5A, 0, 5, 0);
        repeat (TO + 10) @(posedge clk);
        #1;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 0, 11, 0);
        read_key(0);
        chk("timeout_one_code", kvalid, 0);
        chk("timeout_no_err", err_seen, err_exp);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
